stereo_window_generator: RTL and testbench

- Turns the raster-order left/right pixel streams into aligned 5x5 left and right windows.
- These windows are the `i_first_vector_l` / `i_first_vector_r` / `i_valid` inputs of calculationCore. The generator is the producer end of that interface.
- Uses four line buffers per image plus a 5x5 shift-register window per image.
- Emits only windows that lie fully inside the image (no padding).

---
 rtl/stereo_window_generator.sv | 137 +++++++++++++
 tb/tb_stereo_window_generator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_window_generator.sv
// Purpose : builds aligned 5x5 left/right pixel windows from raster-order stereo streams.
// Latency : 1 clock from acceptance of pixel (R>=4, C>=4) to o_valid with that window.
// Backpr. : none; every cycle with i_valid=1 accepts a pixel pair, i_valid=0 freezes state.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid, i_sof          pixel pair present; i_sof forces the pixel to (row 0, col 0)
//   i_pixel_l, i_pixel_r    8-bit left/right pixels
//   o_valid                 window pair valid (fully inside the image)
//   o_vector_l/r            [r][c] window, r=0 top row, c=0 leftmost, [4][4] newest pixel
//   o_center_col/row        image coordinates of window element [2][2]
//   o_frame_done            pulse with the window of the last pixel of a frame
module stereo_window_generator #(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int CW         = $clog2(IMG_WIDTH),
  localparam int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [7:0]            i_pixel_l,
  input  logic [7:0]            i_pixel_r,
  output logic                  o_valid,
  output logic [4:0][4:0][7:0]  o_vector_l,
  output logic [4:0][4:0][7:0]  o_vector_r,
  output logic [CW-1:0]         o_center_col,
  output logic [RW-1:0]         o_center_row,
  output logic                  o_frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;

  // Four line buffers per image, left and right packed as {l, r}.
  // lb_q[0] holds row R-1 at the current column, lb_q[3] holds row R-4.
  logic [15:0] lb_q [4][IMG_WIDTH];

  // Vertical column entering the window: tap[4] is the new pixel, tap[0] the oldest row.
  logic [4:0][7:0] tap_l, tap_r;

  logic [4:0][4:0][7:0] win_l_q, win_r_q;
  logic                 valid_q, done_q;
  logic [CW-1:0]        ccol_q;
  logic [RW-1:0]        crow_q;
  logic                 win_ok;

  // i_sof relocates the accepted pixel to (0,0); the rest of the counter
  // logic works from that effective position.
  always_comb begin
    pos_col = (i_sof) ? '0 : col_q;
    pos_row = (i_sof) ? '0 : row_q;
    col_d   = pos_col + CW'(1);
    row_d   = pos_row;
    if (pos_col == COL_LAST) begin
      col_d = '0;
      row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
    end
  end

  // Windows straddling the left edge still hold columns of the previous line,
  // and the top rows hold stale lines after reset or resync; both are suppressed.
  assign win_ok = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);

  // Read-before-write: taps see the line buffer contents from before this write.
  always_comb begin
    tap_l    = '0;
    tap_r    = '0;
    tap_l[4] = i_pixel_l;
    tap_r[4] = i_pixel_r;
    for (int k = 0; k < 4; k++) begin
      tap_l[3-k] = lb_q[k][pos_col][15:8];
      tap_r[3-k] = lb_q[k][pos_col][7:0];
    end
  end

  // Line buffer contents need no reset: they are only exposed through
  // windows that the win_ok gate has already rejected until overwritten.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb_q[0][pos_col] <= {i_pixel_l, i_pixel_r};
      for (int k = 1; k < 4; k++) begin
        lb_q[k][pos_col] <= lb_q[k-1][pos_col];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_l_q <= '0;
      win_r_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ccol_q  <= '0;
      crow_q  <= '0;
    end else if (i_valid) begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= win_ok;
      done_q  <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_l_q[r][c] <= win_l_q[r][c+1];
          win_r_q[r][c] <= win_r_q[r][c+1];
        end
        win_l_q[r][4] <= tap_l[r];
        win_r_q[r][4] <= tap_r[r];
      end
      if (win_ok) begin
        ccol_q <= pos_col - COL_TWO;
        crow_q <= pos_row - ROW_TWO;
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign o_valid      = valid_q;
  assign o_frame_done = done_q;
  assign o_vector_l   = win_l_q;
  assign o_vector_r   = win_r_q;
  assign o_center_col = ccol_q;
  assign o_center_row = crow_q;

endmodule

// File: tb/tb_stereo_window_generator.sv
// Purpose : directed bench for stereo_window_generator at 8x6 image size.
// Latency : expects each window 1 clock after its bottom-right pixel is accepted.
// Backpr. : none; gaps are driven with i_valid=0 and outputs must hold.
module tb_stereo_window_generator;

  localparam int W = 8;
  localparam int H = 6;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 vld   = 1'b0;
  logic                 sof   = 1'b0;
  logic [7:0]           pl    = 8'h00;
  logic [7:0]           pr    = 8'h00;
  logic                 o_valid;
  logic                 o_frame_done;
  logic [4:0][4:0][7:0] vl, vr;
  logic [2:0]           ccol, crow;

  int errors  = 0;
  int checks  = 0;
  int win_cnt = 0;
  int fd_cnt  = 0;

  // XOR mark distinguishes frames so stale data from an earlier frame is caught.
  logic [7:0]           mark = 8'h00;
  logic [4:0][4:0][7:0] first_vl, first_vr, last_vl;
  logic [5:0]           first_ctr, last_ctr;

  stereo_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (vld),
    .i_sof        (sof),
    .i_pixel_l    (pl),
    .i_pixel_r    (pr),
    .o_valid      (o_valid),
    .o_vector_l   (vl),
    .o_vector_r   (vr),
    .o_center_col (ccol),
    .o_center_row (crow),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    logic [7:0] v;
    v = {r[3:0], c[3:0]};
    return v ^ mark;
  endfunction

  // Expected window for bottom-right pixel (r, c); right image is left + 1.
  function automatic logic [199:0] exp_win(input int r, input int c, input bit right);
    logic [4:0][4:0][7:0] w;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[i][j] = pix(r - 4 + i, c - 4 + j) + (right ? 8'd1 : 8'd0);
    return w;
  endfunction

  // One clock: drive at posedge+1, sample at the following posedge+1.
  task automatic step(input bit v, input bit s, input int r, input int c);
    logic [4:0][4:0][7:0] hl, hr;
    logic [5:0]           hctr;
    logic [5:0]           ectr;
    bit                   exp_v, exp_fd;
    hl   = vl;
    hr   = vr;
    hctr = {crow, ccol};
    vld  = v;
    sof  = s;
    if (v) begin
      pl = pix(r, c);
      pr = pix(r, c) + 8'd1;
    end else begin
      pl = 8'($urandom);
      pr = 8'($urandom);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    sof = 1'b0;
    if (!v) begin
      check("gap_valid", 200'(o_valid), 200'(1'b0));
      check("gap_done", 200'(o_frame_done), 200'(1'b0));
      check("gap_hold_l", vl, hl);
      check("gap_hold_r", vr, hr);
      check("gap_hold_ctr", 200'({crow, ccol}), 200'(hctr));
    end else begin
      exp_v  = (r >= 4) && (c >= 4);
      exp_fd = (r == H - 1) && (c == W - 1);
      check("valid", 200'(o_valid), 200'(exp_v));
      check("frame_done", 200'(o_frame_done), 200'(exp_fd));
      if (exp_v) begin
        ectr = {3'(r - 2), 3'(c - 2)};
        check("centre", 200'({crow, ccol}), 200'(ectr));
        check("win_l", vl, exp_win(r, c, 1'b0));
        check("win_r", vr, exp_win(r, c, 1'b1));
      end
    end
    if (o_valid) begin
      win_cnt++;
      if (win_cnt == 1) begin
        first_vl  = vl;
        first_vr  = vr;
        first_ctr = {crow, ccol};
      end
      last_vl  = vl;
      last_ctr = {crow, ccol};
    end
    if (o_frame_done) fd_cnt++;
  endtask

  // Sends raster pixels first..last (flat index), optional sof on the first one,
  // optional idle gaps of 1..3 cycles before every pixel.
  task automatic frame(input bit use_sof, input bit gaps, input int first, input int last);
    for (int idx = first; idx <= last; idx++) begin
      if (gaps) begin
        int n;
        n = int'($urandom_range(1, 3));
        for (int g = 0; g < n; g++) step(1'b0, 1'b0, 0, 0);
      end
      step(1'b1, use_sof && (idx == first), idx / W, idx % W);
    end
  endtask

  localparam int LAST = W * H - 1;

  initial begin
    int n1;
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 200'(o_valid), 200'(1'b0));
    check("rst_done", 200'(o_frame_done), 200'(1'b0));
    check("rst_vec_l", vl, 200'(0));
    check("rst_vec_r", vr, 200'(0));
    check("rst_ctr", 200'({crow, ccol}), 200'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single continuous frame
    win_cnt = 0; fd_cnt = 0; mark = 8'h00;
    frame(1'b1, 1'b0, 0, LAST);
    check("s1_windows", 200'(win_cnt), 200'(8));
    check("s1_done_cnt", 200'(fd_cnt), 200'(1));
    check("s1_first_ctr", 200'(first_ctr), 200'(6'o22));
    check("s1_first_00", 200'(first_vl[0][0]), 200'(8'h00));
    check("s1_first_22", 200'(first_vl[2][2]), 200'(8'h22));
    check("s1_first_44", 200'(first_vl[4][4]), 200'(8'h44));
    check("s1_first_r44", 200'(first_vr[4][4]), 200'(8'h45));
    check("s1_last_ctr", 200'(last_ctr), 200'(6'o35));
    check("s1_last_44", 200'(last_vl[4][4]), 200'(8'h57));

    // 2: same frame with idle gaps
    win_cnt = 0; fd_cnt = 0;
    frame(1'b1, 1'b1, 0, LAST);
    check("s2_windows", 200'(win_cnt), 200'(8));
    check("s2_done_cnt", 200'(fd_cnt), 200'(1));

    // 3: back-to-back frames, sof only on the first
    win_cnt = 0; fd_cnt = 0;
    frame(1'b1, 1'b0, 0, LAST);
    n1 = win_cnt;
    win_cnt = 0;
    frame(1'b0, 1'b0, 0, LAST);
    check("s3_windows", 200'(n1 + win_cnt), 200'(16));
    check("s3_done_cnt", 200'(fd_cnt), 200'(2));
    check("s3_f2_first_ctr", 200'(first_ctr), 200'(6'o22));
    check("s3_f2_first_44", 200'(first_vl[4][4]), 200'(8'h44));

    // 4: resync at frame-1 pixel (3,2); frame 2 carries a different mark
    win_cnt = 0; fd_cnt = 0; mark = 8'h00;
    frame(1'b1, 1'b0, 0, 3 * W + 1);
    mark = 8'h80;
    frame(1'b1, 1'b0, 0, LAST);
    check("s4_windows", 200'(win_cnt), 200'(8));
    check("s4_first_ctr", 200'(first_ctr), 200'(6'o22));
    check("s4_first_44", 200'(first_vl[4][4]), 200'(8'hC4));
    check("s4_first_00", 200'(first_vl[0][0]), 200'(8'h80));

    // 5: asynchronous reset between edges, mid-frame
    mark = 8'h00;
    frame(1'b1, 1'b0, 0, 4 * W + 5);
    check("s5_pre_valid", 200'(o_valid), 200'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_valid", 200'(o_valid), 200'(1'b0));
    check("s5_rst_done", 200'(o_frame_done), 200'(1'b0));
    check("s5_rst_vec_l", vl, 200'(0));
    check("s5_rst_vec_r", vr, 200'(0));
    check("s5_rst_ctr", 200'({crow, ccol}), 200'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    win_cnt = 0; fd_cnt = 0; mark = 8'h33;
    frame(1'b0, 1'b0, 0, LAST);
    check("s5_windows", 200'(win_cnt), 200'(8));
    check("s5_done_cnt", 200'(fd_cnt), 200'(1));

    // 6: line wrap at row 5
    win_cnt = 0; mark = 8'h00;
    frame(1'b1, 1'b0, 0, 5 * W + 4);
    check("s6_wrap_cnt", 200'(win_cnt), 200'(5));
    check("s6_wrap_ctr", 200'(last_ctr), 200'(6'o32));
    check("s6_wrap_00", 200'(last_vl[0][0]), 200'(8'h10));
    frame(1'b0, 1'b0, 5 * W + 5, LAST);
    check("s6_windows", 200'(win_cnt), 200'(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
